// File: rtl/hook_pkg.sv
// Shared types and geometry limits for the swinging hook.
package hook_pkg;

  typedef enum logic [1:0] {
    StSwing,
    StExtend,
    StRetract
  } hook_state_e;

  localparam int unsigned MIN_LEN    = 16;
  localparam int unsigned MAX_LEN    = 400;
  localparam int unsigned ANGLE_LIM  = 80;
  localparam int unsigned CLIP_X_MIN = 10;
  localparam int unsigned CLIP_X_MAX = 629;
  localparam int unsigned CLIP_Y_MAX = 470;

endpackage

// File: rtl/hook_trig_lut.sv
// Dual-read sine table: S(d) = round(256 * sin(d deg)) for d = 0..90.
module hook_trig_lut (
  input  logic [6:0] deg_a_i,
  input  logic [6:0] deg_b_i,
  output logic [8:0] sin_a_o,
  output logic [8:0] sin_b_o
);

  localparam logic [8:0] SinTab [91] = '{
    9'd0,   9'd4,   9'd9,   9'd13,  9'd18,  9'd22,  9'd27,  9'd31,  9'd36,  9'd40,
    9'd44,  9'd49,  9'd53,  9'd58,  9'd62,  9'd66,  9'd71,  9'd75,  9'd79,  9'd83,
    9'd88,  9'd92,  9'd96,  9'd100, 9'd104, 9'd108, 9'd112, 9'd116, 9'd120, 9'd124,
    9'd128, 9'd132, 9'd136, 9'd139, 9'd143, 9'd147, 9'd150, 9'd154, 9'd158, 9'd161,
    9'd165, 9'd168, 9'd171, 9'd175, 9'd178, 9'd181, 9'd184, 9'd187, 9'd190, 9'd193,
    9'd196, 9'd199, 9'd202, 9'd204, 9'd207, 9'd210, 9'd212, 9'd215, 9'd217, 9'd219,
    9'd222, 9'd224, 9'd226, 9'd228, 9'd230, 9'd232, 9'd234, 9'd236, 9'd237, 9'd239,
    9'd241, 9'd242, 9'd243, 9'd245, 9'd246, 9'd247, 9'd248, 9'd249, 9'd250, 9'd251,
    9'd252, 9'd253, 9'd254, 9'd254, 9'd255, 9'd255, 9'd255, 9'd256, 9'd256, 9'd256,
    9'd256
  };

  // Out-of-range degrees saturate to sin(90).
  assign sin_a_o = (deg_a_i > 7'd90) ? 9'd256 : SinTab[deg_a_i];
  assign sin_b_o = (deg_b_i > 7'd90) ? 9'd256 : SinTab[deg_b_i];

endmodule

// File: rtl/hook.sv
// Swinging grappling hook: pendulum sweep, fire, extend, retract, tip position output.
// Optional screen-edge stop on extension: define HOOK_SCREEN_CLIP_EN.
module hook
  import hook_pkg::*;
#(
  parameter int unsigned OFFSET_X        = 320,
  parameter int unsigned OFFSET_Y        = 96,
  parameter int unsigned EXTENTION_SPEED = 5,
  parameter int unsigned ROTATION_SPEED  = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        enable,
  input  logic        startOfFrame,
  input  logic        sendHook,
  output logic [10:0] x,
  output logic [10:0] y
);

  hook_state_e       state_q;
  logic signed [7:0] angle_q, angle_d;
  logic              dir_q, dir_d;
  logic [8:0]        len_q;
  logic              latch_q;
  logic [10:0]       x_q, x_d, y_q, y_d;

  logic [6:0]        ang_abs, deg_cos;
  logic [8:0]        sin_a, sin_b;
  logic [9:0]        off_x, off_y;
  logic signed [8:0] ang_sum, ang_step, ang_lim;
  logic [9:0]        len_ext;
  logic              clip;
  logic              tick;

  assign tick = startOfFrame & enable;

  hook_trig_lut u_lut (
    .deg_a_i(ang_abs),
    .deg_b_i(deg_cos),
    .sin_a_o(sin_a),
    .sin_b_o(sin_b)
  );

  always_comb begin
    ang_abs = angle_q[7] ? 7'(-angle_q) : 7'(angle_q);
    deg_cos = 7'd90 - ang_abs;
    off_x   = 10'((18'(len_q) * 18'(sin_a)) >> 8);
    off_y   = 10'((18'(len_q) * 18'(sin_b)) >> 8);
    x_d     = angle_q[7] ? 11'(OFFSET_X) - {1'b0, off_x} : 11'(OFFSET_X) + {1'b0, off_x};
    y_d     = 11'(OFFSET_Y) + {1'b0, off_y};
  end

  // Swing step, bouncing off the angle limit as soon as it is reached.
  always_comb begin
    ang_step = $signed(9'(ROTATION_SPEED));
    ang_lim  = $signed(9'(ANGLE_LIM));
    ang_sum  = dir_q ? $signed({angle_q[7], angle_q}) + ang_step
                     : $signed({angle_q[7], angle_q}) - ang_step;
    angle_d  = ang_sum[7:0];
    dir_d    = dir_q;
    if (ang_sum >= ang_lim) begin
      angle_d = ang_lim[7:0];
      dir_d   = 1'b0;
    end else if (ang_sum <= -ang_lim) begin
      angle_d = 8'(-ang_lim);
      dir_d   = 1'b1;
    end
  end

  assign len_ext = {1'b0, len_q} + 10'(EXTENTION_SPEED);

`ifdef HOOK_SCREEN_CLIP_EN
  assign clip = (y_q >= 11'(CLIP_Y_MAX)) || (x_q < 11'(CLIP_X_MIN)) || (x_q > 11'(CLIP_X_MAX));
`else
  assign clip = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StSwing;
      angle_q <= '0;
      dir_q   <= 1'b1;
      len_q   <= 9'(MIN_LEN);
      latch_q <= 1'b0;
      x_q     <= 11'(OFFSET_X);
      y_q     <= 11'(OFFSET_Y + MIN_LEN);
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (sendHook) latch_q <= 1'b1;
      if (!enable) begin
        state_q <= StSwing;
        angle_q <= '0;
        dir_q   <= 1'b1;
        len_q   <= 9'(MIN_LEN);
        latch_q <= 1'b0;
      end else if (tick) begin
        unique case (state_q)
          StSwing: begin
            if (latch_q) begin
              state_q <= StExtend;
              latch_q <= 1'b0;
            end else begin
              angle_q <= angle_d;
              dir_q   <= dir_d;
            end
          end
          StExtend: begin
            latch_q <= 1'b0;
            if (len_ext > 10'(MAX_LEN) || clip) state_q <= StRetract;
            else                                len_q   <= len_ext[8:0];
          end
          StRetract: begin
            latch_q <= 1'b0;
            if ({1'b0, len_q} <= 10'(MIN_LEN + EXTENTION_SPEED)) begin
              len_q   <= 9'(MIN_LEN);
              state_q <= StSwing;
            end else begin
              len_q <= len_q - 9'(EXTENTION_SPEED);
            end
          end
          default: state_q <= StSwing;
        endcase
      end
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: tb/tb_hook.sv
// Self-checking bench for hook: constant-vector table plus a per-tick scoreboard model.
module tb_hook;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        sendHook = 1'b0;
  logic [10:0] x, y;

  hook #(
    .OFFSET_X(320),
    .OFFSET_Y(96),
    .EXTENTION_SPEED(5),
    .ROTATION_SPEED(2)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .enable(enable),
    .startOfFrame(startOfFrame),
    .sendHook(sendHook),
    .x(x),
    .y(y)
  );

  always #5 clk = ~clk;

`ifdef HOOK_SCREEN_CLIP_EN
  localparam bit ClipOn = 1'b1;
`else
  localparam bit ClipOn = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state: 0 = swing, 1 = extend, 2 = retract.
  int m_a, m_len, m_st;
  bit m_dir, m_latch;
  int sin_tab[91];

  typedef struct {int ex; int ey;} xy_t;
  xy_t sb[$];

  typedef struct {string name; bit send; int ticks; int ex; int ey;} vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int m_x();
    int d   = (m_a < 0) ? -m_a : m_a;
    int off = (m_len * sin_tab[d]) >> 8;
    return (m_a < 0) ? 320 - off : 320 + off;
  endfunction

  function automatic int m_y();
    int d = (m_a < 0) ? -m_a : m_a;
    return 96 + ((m_len * sin_tab[90 - d]) >> 8);
  endfunction

  function automatic void m_init();
    m_a = 0; m_dir = 1'b1; m_len = 16; m_st = 0; m_latch = 1'b0;
  endfunction

  function automatic void m_step();
    bit c = ClipOn && (m_y() >= 470 || m_x() < 10 || m_x() > 629);
    case (m_st)
      0: begin
        if (m_latch) begin
          m_st = 1; m_latch = 1'b0;
        end else begin
          m_a = m_dir ? m_a + 2 : m_a - 2;
          if (m_a >= 80) begin m_a = 80; m_dir = 1'b0; end
          else if (m_a <= -80) begin m_a = -80; m_dir = 1'b1; end
        end
      end
      1: begin
        m_latch = 1'b0;
        if (m_len + 5 > 400 || c) m_st = 2;
        else m_len = m_len + 5;
      end
      default: begin
        m_latch = 1'b0;
        if (m_len - 5 <= 16) begin m_len = 16; m_st = 0; end
        else m_len = m_len - 5;
      end
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0; enable = 1'b1; sendHook = 1'b0; startOfFrame = 1'b0;
    m_init();
    sb.delete();
    @(negedge clk);
    check("reset_x", int'(x), 320);
    check("reset_y", int'(y), 112);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick();
    xy_t e;
    @(negedge clk);
    startOfFrame = 1'b1;
    @(posedge clk);
    #1 startOfFrame = 1'b0;
    m_step();
    sb.push_back('{m_x(), m_y()});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check("sb_x", int'(x), e.ex);
    check("sb_y", int'(y), e.ey);
  endtask

  task automatic send_pulse();
    @(negedge clk);
    sendHook = 1'b1;
    @(negedge clk);
    sendHook = 1'b0;
    m_latch = 1'b1;
  endtask

  initial begin
    for (int d = 0; d <= 90; d++)
      sin_tab[d] = $rtoi(256.0 * $sin(d * 3.14159265358979 / 180.0) + 0.5);

    vecs.push_back('{"idle",       1'b0, 0,   320, 112});
    vecs.push_back('{"a40",        1'b0, 20,  330, 108});
    vecs.push_back('{"a80",        1'b0, 40,  335, 98});
    vecs.push_back('{"a78",        1'b0, 41,  335, 99});
    vecs.push_back('{"am80",       1'b0, 120, 305, 98});
    vecs.push_back('{"fire",       1'b1, 1,   320, 112});
    vecs.push_back('{"ext72",      1'b1, 73,  320, 472});
`ifdef HOOK_SCREEN_CLIP_EN
    vecs.push_back('{"clip_ret",   1'b1, 74,  320, 472});
    vecs.push_back('{"clip_ret1",  1'b1, 75,  320, 467});
    vecs.push_back('{"clip_home",  1'b1, 146, 320, 112});
`else
    vecs.push_back('{"ext_max",    1'b1, 77,  320, 492});
    vecs.push_back('{"max_ret",    1'b1, 78,  320, 492});
    vecs.push_back('{"max_ret1",   1'b1, 79,  320, 487});
    vecs.push_back('{"max_home",   1'b1, 154, 320, 112});
`endif

    foreach (vecs[i]) begin
      do_reset();
      if (vecs[i].send) send_pulse();
      repeat (vecs[i].ticks) tick();
      check({vecs[i].name, "_x"}, int'(x), vecs[i].ex);
      check({vecs[i].name, "_y"}, int'(y), vecs[i].ey);
    end

    // Enable dropped mid-extend: state clears next clk, outputs one clk later.
    begin
      int old_x, old_y;
      do_reset();
      repeat (5) tick();
      send_pulse();
      repeat (11) tick();
      old_x = m_x();
      old_y = m_y();
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      #1 enable = 1'b1;
      m_init();
      check("en_drop_lag_x", int'(x), old_x);
      check("en_drop_lag_y", int'(y), old_y);
      @(posedge clk);
      #1;
      check("en_drop_x", int'(x), 320);
      check("en_drop_y", int'(y), 112);
      repeat (3) tick();
    end

    // Asynchronous reset mid-extend.
    begin
      do_reset();
      repeat (3) tick();
      send_pulse();
      repeat (10) tick();
      @(negedge clk);
      #2 resetN = 1'b0;
      #1;
      check("async_rst_x", int'(x), 320);
      check("async_rst_y", int'(y), 112);
      m_init();
      @(negedge clk);
      resetN = 1'b1;
      repeat (3) tick();
    end

    // Fire request during retract must not re-launch after returning to swing.
    begin
      int guard;
      do_reset();
      send_pulse();
      guard = 0;
      while (m_st != 2 && guard < 200) begin tick(); guard++; end
      check("reach_retract", int'(m_st == 2), 1);
      tick();
      send_pulse();
      guard = 0;
      while (m_st != 0 && guard < 200) begin tick(); guard++; end
      check("reach_swing", int'(m_st == 0), 1);
      repeat (5) tick();
      check("no_refire_x", int'(x), 322);
      check("no_refire_y", int'(y), 111);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
